// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stall/flush controller: action encodings
// and the branch/jump opcode constants used by the ID-stage decode.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_STALL    = 2'b01,
    ST_WAIT     = 2'b10,
    ST_REDIRECT = 2'b11
  } state_t;

  localparam logic [6:0] bOp    = 7'h63;
  localparam logic [6:0] jalrOp = 7'h67;

endpackage

// File: rtl/pipeline_control_if.sv
// Request inputs, stage enables/flushes and status counters of the controller.
// master = pipeline side raising requests, slave = the controller itself.
interface pipeline_control_if #(parameter int CNT_W = 32);

  logic             nop;
  logic             branchTaken;
  logic             memBusy;
  logic             counterClear;
  logic             pcWrite;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_write;
  logic             ID_EX_flush;
  logic             EX_MEM_write;
  logic             MEM_WB_write;
  logic [1:0]       state;
  logic             hazardError;
  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] flushCount;
  logic [CNT_W-1:0] memWaitCycles;
  logic [CNT_W-1:0] cycleCount;

  modport master (
    output nop, branchTaken, memBusy, counterClear,
    input  pcWrite, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
           EX_MEM_write, MEM_WB_write, state, hazardError,
           stallCycles, flushCount, memWaitCycles, cycleCount
  );

  modport slave (
    input  nop, branchTaken, memBusy, counterClear,
    output pcWrite, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
           EX_MEM_write, MEM_WB_write, state, hazardError,
           stallCycles, flushCount, memWaitCycles, cycleCount
  );

endinterface

// File: rtl/pipeline_control_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over
// the increment; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count register: clear first, then increment unless already saturated
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= {W{1'b0}};
    end else if (i_clear) begin
      r_count <= {W{1'b0}};
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_control.sv
// Central stall/flush controller: combinational stage enables from a fixed
// priority action decode, plus registered action, stall watchdog and counters.
module pipeline_control
  import pipeline_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 4
) (
  input  logic              clock,
  input  logic              reset,
  pipeline_control_if.slave bus
);

  localparam int NR_W = $clog2(MAX_STALL + 1);
  localparam logic [NR_W-1:0] NR_MAX = NR_W'(MAX_STALL);

  state_t          w_action;
  state_t          r_state;
  logic [NR_W-1:0] r_nop_run;
  logic [NR_W-1:0] w_nop_run_next;
  logic            r_hazard_error;
  logic [6:0]      w_ctrl;

  // Action decode: memory busy freezes everything, hazard stall beats redirect
  always_comb begin
    w_action = ST_RUN;
    if (bus.memBusy) begin
      w_action = ST_WAIT;
    end else if (bus.nop) begin
      w_action = ST_STALL;
    end else if (bus.branchTaken) begin
      w_action = ST_REDIRECT;
    end else begin
      w_action = ST_RUN;
    end
  end

  // Stage controls {pcW, IFIDw, IFIDf, IDEXw, IDEXf, EXMEMw, MEMWBw}, gated by reset
  always_comb begin
    w_ctrl = 7'b000_0000;
    if (reset) begin
      case (w_action)
        ST_WAIT:     w_ctrl = 7'b000_0000;
        ST_STALL:    w_ctrl = 7'b000_1111;
        ST_REDIRECT: w_ctrl = 7'b111_1011;
        ST_RUN:      w_ctrl = 7'b110_1011;
        default:     w_ctrl = 7'b000_0000;
      endcase
    end else begin
      w_ctrl = 7'b000_0000;
    end
  end

  assign {bus.pcWrite, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_write,
          bus.ID_EX_flush, bus.EX_MEM_write, bus.MEM_WB_write} = w_ctrl;

  // Watchdog run length: a memory wait pauses it rather than breaking the run
  always_comb begin
    w_nop_run_next = r_nop_run;
    case (w_action)
      ST_STALL: w_nop_run_next = (r_nop_run == NR_MAX) ? r_nop_run : r_nop_run + NR_W'(1);
      ST_WAIT:  w_nop_run_next = r_nop_run;
      default:  w_nop_run_next = {NR_W{1'b0}};
    endcase
  end

  // Action state and sticky watchdog, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_RUN;
      r_nop_run      <= {NR_W{1'b0}};
      r_hazard_error <= 1'b0;
    end else begin
      r_state        <= w_action;
      r_nop_run      <= w_nop_run_next;
      r_hazard_error <= r_hazard_error | (w_nop_run_next == NR_MAX);
    end
  end

  assign bus.state       = r_state;
  assign bus.hazardError = r_hazard_error;

  sat_counter #(.W(CNT_W)) u_cycle (
    .clock(clock), .reset(reset), .i_inc(1'b1),
    .i_clear(bus.counterClear), .o_count(bus.cycleCount)
  );

  sat_counter #(.W(CNT_W)) u_stall (
    .clock(clock), .reset(reset), .i_inc(w_action == ST_STALL),
    .i_clear(bus.counterClear), .o_count(bus.stallCycles)
  );

  sat_counter #(.W(CNT_W)) u_memwait (
    .clock(clock), .reset(reset), .i_inc(w_action == ST_WAIT),
    .i_clear(bus.counterClear), .o_count(bus.memWaitCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clock(clock), .reset(reset), .i_inc(w_action == ST_REDIRECT),
    .i_clear(bus.counterClear), .o_count(bus.flushCount)
  );

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: directed scenarios then random
// traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_control;

  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 4;
  localparam int MAXC      = (1 << CNT_W) - 1;

  logic clock;
  logic reset;

  pipeline_control_if #(.CNT_W(CNT_W)) bus ();

  pipeline_control #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_vec = 0;
  int n_err = 0;

  // model: 0 RUN, 1 STALL, 2 WAIT, 3 REDIRECT
  int m_state, m_run, m_cyc, m_stl, m_mw, m_fl;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int act_of(input bit n, input bit b, input bit m);
    if (m) return 2;
    if (n) return 1;
    if (b) return 3;
    return 0;
  endfunction

  // {pcWrite, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write, MEM_WB_write}
  function automatic logic [6:0] en_of(input int a);
    case (a)
      1: return 7'b0001111;
      2: return 7'b0000000;
      3: return 7'b1111011;
      default: return 7'b1101011;
    endcase
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  function automatic logic [6:0] dut_en();
    return {bus.pcWrite, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_write,
            bus.ID_EX_flush, bus.EX_MEM_write, bus.MEM_WB_write};
  endfunction

  task automatic model_reset();
    m_state = 0; m_run = 0; m_err = 1'b0;
    m_cyc = 0; m_stl = 0; m_mw = 0; m_fl = 0;
  endtask

  task automatic model_edge(input bit n, input bit b, input bit m, input bit c);
    int a;
    a = act_of(n, b, m);
    if (c) begin
      m_cyc = 0; m_stl = 0; m_mw = 0; m_fl = 0;
    end else begin
      m_cyc = sat_inc(m_cyc);
      if (a == 1) m_stl = sat_inc(m_stl);
      if (a == 2) m_mw  = sat_inc(m_mw);
      if (a == 3) m_fl  = sat_inc(m_fl);
    end
    if (a == 1)      m_run = (m_run >= MAX_STALL) ? MAX_STALL : m_run + 1;
    else if (a != 2) m_run = 0;
    if (m_run == MAX_STALL) m_err = 1'b1;
    m_state = a;
  endtask

  task automatic chk_regs();
    chk("state",         32'(bus.state),         32'(m_state));
    chk("hazardError",   32'(bus.hazardError),   32'(m_err));
    chk("cycleCount",    32'(bus.cycleCount),    32'(m_cyc));
    chk("stallCycles",   32'(bus.stallCycles),   32'(m_stl));
    chk("memWaitCycles", 32'(bus.memWaitCycles), 32'(m_mw));
    chk("flushCount",    32'(bus.flushCount),    32'(m_fl));
  endtask

  // called just after a rising edge; returns just after the next one
  task automatic step(input bit n, input bit b, input bit m, input bit c);
    bus.nop = n; bus.branchTaken = b; bus.memBusy = m; bus.counterClear = c;
    #1;
    chk("enables", 32'(dut_en()), 32'(en_of(act_of(n, b, m))));
    @(posedge clock);
    model_edge(n, b, m, c);
    #1;
    chk_regs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.nop = 1'($urandom); bus.branchTaken = 1'($urandom);
    bus.memBusy = 1'($urandom); bus.counterClear = 1'($urandom);
    #1;
    model_reset();
    chk("enables_in_reset", 32'(dut_en()), 32'd0);
    chk_regs();
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    bus.nop = 1'b0; bus.branchTaken = 1'b0; bus.memBusy = 1'b0; bus.counterClear = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    do_reset();

    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("cycle5", 32'(bus.cycleCount), 32'd5);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall2", 32'(bus.stallCycles), 32'd2);
    chk("noerr2", 32'(bus.hazardError), 32'd0);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush1", 32'(bus.flushCount), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("memwait3", 32'(bus.memWaitCycles), 32'd3);
    chk("noerr_wait", 32'(bus.hazardError), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("err_4th", 32'(bus.hazardError), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("err_after_clear", 32'(bus.hazardError), 32'd1);
    do_reset();

    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (17) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("cycle_sat", 32'(bus.cycleCount), 32'd15);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("cycle_clr", 32'(bus.cycleCount), 32'd0);

    for (int i = 0; i < 400; i++) begin
      if ((i % 150) == 149) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
